// File: rtl/ft_wr_master.sv
// FTDI synchronous-FIFO write master: user words are buffered in a 2-entry FIFO
// and streamed to the FTDI in WR_N-low bursts of at most MAX_BURST words.
module ft_wr_master #(
   parameter int D_BIT     = 32,
   parameter int BE_BIT    = 4,
   parameter int MAX_BURST = 256
) (
   input  logic              iCLK,
   input  logic              iRESET_N,
   input  logic [D_BIT-1:0]  iDATA,
   input  logic [BE_BIT-1:0] iBE,
   input  logic              iVALID,
   output logic              oREADY,
   input  logic              iTXE_N,
   output logic              oWR_N,
   output logic [D_BIT-1:0]  oDATA,
   output logic [BE_BIT-1:0] oBE,
   output logic              oDATA_OE,
   output logic              oBURST_DONE,
   output logic [15:0]       oWORD_CNT
);

   localparam int              BC_W       = $clog2(MAX_BURST + 1);
   localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, SETUP, WRITE, END} state_t;

   state_t                 state_q, state_d;
   logic [1:0][D_BIT-1:0]  data_q, data_d;
   logic [1:0][BE_BIT-1:0] be_q, be_d;
   logic                   wr_ptr_q, wr_ptr_d;
   logic                   rd_ptr_q, rd_ptr_d;
   logic [1:0]             count_q, count_d;
   logic                   rdy_en_q, rdy_en_d;
   logic [BC_W-1:0]        burst_q, burst_d;
   logic [15:0]            word_cnt_q, word_cnt_d;
   logic                   push, pop;

   // oREADY stays low until the first edge after reset release
   assign oREADY    = rdy_en_q && (count_q < 2'd2);
   assign oDATA     = data_q[rd_ptr_q];
   assign oBE       = be_q[rd_ptr_q];
   assign oWORD_CNT = word_cnt_q;

   assign push = iVALID && oREADY;
   assign pop  = (state_q == WRITE) && !iTXE_N;

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      be_d        = be_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rdy_en_d    = 1'b1;
      burst_d     = burst_q;
      word_cnt_d  = word_cnt_q;
      oWR_N       = 1'b1;
      oDATA_OE    = 1'b0;
      oBURST_DONE = 1'b0;

      if (push) begin
         data_d[wr_ptr_q] = iDATA;
         be_d[wr_ptr_q]   = iBE;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d   = ~rd_ptr_q;
         word_cnt_d = word_cnt_q + 16'd1;
      end
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end

      case (state_q)
         IDLE: begin
            if ((count_q != 2'd0) && !iTXE_N) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            oDATA_OE = 1'b1;
            state_d  = WRITE;
         end
         WRITE: begin
            oDATA_OE = 1'b1;
            oWR_N    = 1'b0;
            if (pop) begin
               burst_d = burst_q + 1'b1;
            end
            // Leave on FTDI back-pressure, on draining the FIFO, or at a full burst
            if (iTXE_N || (pop && !push && (count_q == 2'd1)) ||
                (pop && (burst_q == BURST_LAST))) begin
               state_d = END;
            end
         end
         END: begin
            oDATA_OE    = 1'b1;
            oBURST_DONE = 1'b1;
            burst_d     = '0;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESET_N) begin
      if (!iRESET_N) begin
         state_q    <= IDLE;
         data_q     <= '0;
         be_q       <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         rdy_en_q   <= 1'b0;
         burst_q    <= '0;
         word_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         be_q       <= be_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rdy_en_q   <= rdy_en_d;
         burst_q    <= burst_d;
         word_cnt_q <= word_cnt_d;
      end
   end

endmodule

// File: tb/tb_ft_wr_master.sv
// Self-checking bench for ft_wr_master: a queue-based FIFO/FTDI model is checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_ft_wr_master;

   localparam int MAX = 256;
   localparam int P_IDLE = 0, P_SETUP = 1, P_WRITE = 2, P_END = 3, P_BAD = 4;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  be;
   } word_t;

   logic        iCLK, iRESET_N, iVALID, iTXE_N;
   logic [31:0] iDATA;
   logic [3:0]  iBE;
   logic        oREADY, oWR_N, oDATA_OE, oBURST_DONE;
   logic [31:0] oDATA;
   logic [3:0]  oBE;
   logic [15:0] oWORD_CNT;

   ft_wr_master #(.D_BIT(32), .BE_BIT(4), .MAX_BURST(MAX)) dut (
      .iCLK(iCLK), .iRESET_N(iRESET_N), .iDATA(iDATA), .iBE(iBE),
      .iVALID(iVALID), .oREADY(oREADY), .iTXE_N(iTXE_N), .oWR_N(oWR_N),
      .oDATA(oDATA), .oBE(oBE), .oDATA_OE(oDATA_OE),
      .oBURST_DONE(oBURST_DONE), .oWORD_CNT(oWORD_CNT)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   int compared = 0;
   int mismatched = 0;

   // Model state: words held by the block and what the FTDI has taken
   word_t       mq[$];
   logic [15:0] mcnt;
   int          burstPops, relEdges, prevPh, highRun, lowCnt, doneCnt, pushCnt;
   bit          prevExit, prevIdleGo, seenBurst, stimDone;
   int          burstLens[$];
   int          gapLens[$];
   logic [31:0] firstWords[$];
   logic [31:0] capWords[$];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Samples outputs mid-cycle, predicts the next edge from the interface rules
   always @(negedge iCLK) begin : monitor
      int    cur, expPh;
      bit    push, pop, exitNow;
      word_t w;
      if (!iRESET_N) begin
         checkOutput("rst_ready", oREADY, 0);
         checkOutput("rst_wr_n", oWR_N, 1);
         checkOutput("rst_oe", oDATA_OE, 0);
         checkOutput("rst_data", oDATA, 0);
         checkOutput("rst_be", oBE, 0);
         checkOutput("rst_done", oBURST_DONE, 0);
         checkOutput("rst_cnt", oWORD_CNT, 0);
         mq.delete();
         mcnt = 16'd0; burstPops = 0; relEdges = 0; prevPh = P_IDLE; highRun = 0;
         prevExit = 0; prevIdleGo = 0; seenBurst = 0;
      end else begin
         if (!oWR_N) cur = (oDATA_OE && !oBURST_DONE) ? P_WRITE : P_BAD;
         else if (oBURST_DONE) cur = oDATA_OE ? P_END : P_BAD;
         else cur = oDATA_OE ? P_SETUP : P_IDLE;
         case (prevPh)
            P_IDLE:  expPh = prevIdleGo ? P_SETUP : P_IDLE;
            P_SETUP: expPh = P_WRITE;
            P_WRITE: expPh = prevExit ? P_END : P_WRITE;
            P_END:   expPh = P_IDLE;
            default: expPh = cur;
         endcase
         checkOutput("phase", cur, expPh);
         checkOutput("ready", oREADY, (relEdges > 0) && (mq.size() < 2));
         checkOutput("word_cnt", oWORD_CNT, mcnt);
         if (cur == P_SETUP || cur == P_WRITE) begin
            checkOutput("head_valid", mq.size() > 0, 1);
            if (mq.size() > 0) begin
               checkOutput("head_data", oDATA, mq[0].d);
               checkOutput("head_be", oBE, mq[0].be);
            end
         end
         prevIdleGo = (mq.size() > 0) && !iTXE_N;
         push = iVALID && oREADY;
         pop  = !oWR_N && !iTXE_N && (mq.size() > 0);
         if (!oWR_N) lowCnt++;
         if (oBURST_DONE) doneCnt++;
         if (cur == P_WRITE && prevPh != P_WRITE) begin
            if (seenBurst) gapLens.push_back(highRun);
            highRun = 0;
         end else if (oWR_N) begin
            highRun++;
         end
         if (pop) begin
            w = mq.pop_front();
            if (burstPops == 0) firstWords.push_back(w.d);
            capWords.push_back(w.d);
            mcnt = mcnt + 16'd1;
            burstPops++;
         end
         if (push) begin
            w.d = iDATA; w.be = iBE;
            mq.push_back(w);
            pushCnt++;
         end
         exitNow = 0;
         if (cur == P_WRITE) begin
            exitNow = iTXE_N || (pop && mq.size() == 0) || (burstPops == MAX);
            if (exitNow) begin
               burstLens.push_back(burstPops);
               burstPops = 0;
               seenBurst = 1;
            end
         end
         prevExit = exitNow;
         prevPh = cur;
         if (relEdges < 2) relEdges++;
      end
   end

   task automatic clearLogs();
      burstLens.delete(); gapLens.delete(); firstWords.delete(); capWords.delete();
      lowCnt = 0; doneCnt = 0; pushCnt = 0;
   endtask

   task automatic resetDut();
      iRESET_N = 1'b0; iVALID = 1'b0; iTXE_N = 1'b1;
      repeat (3) @(posedge iCLK);
      #1 iRESET_N = 1'b1;
      clearLogs();
   endtask

   // Offers n words; counts only handshaked ones
   task automatic applyStimulus(input int n, input logic [31:0] base, input bit randomData,
                                input int validPct, input int budget);
      int k = 0;
      int cyc = 0;
      bit acc;
      while (k < n && cyc < budget) begin
         iVALID = ($urandom_range(99) < validPct);
         iDATA  = randomData ? $urandom : base + k;
         iBE    = randomData ? 4'($urandom_range(15)) : 4'hF;
         @(negedge iCLK);
         acc = iVALID && oREADY;
         @(posedge iCLK);
         #1;
         if (acc) k++;
         cyc++;
      end
      iVALID = 1'b0;
      if (k < n) checkOutput("push_budget", k, n);
   endtask

   task automatic waitIdle(input int budget);
      int c = 0;
      do begin
         @(posedge iCLK); #2; c++;
      end while (!(mq.size() == 0 && oDATA_OE == 1'b0) && c < budget);
      if (c >= budget) checkOutput("drain_timeout", c, 0);
   endtask

   task automatic checkIdx(input string name, input int q[$], input int idx, input int exp);
      if (q.size() > idx) checkOutput(name, q[idx], exp);
      else checkOutput({name, "_missing"}, q.size(), idx + 1);
   endtask

   initial begin : watchdog
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      iRESET_N = 1'b0; iVALID = 1'b0; iTXE_N = 1'b1; iDATA = '0; iBE = '0;
      stimDone = 0;

      // Single word
      resetDut();
      iTXE_N = 1'b0;
      iDATA = 32'hA5A5_0001; iBE = 4'hF; iVALID = 1'b1;
      @(posedge iCLK); #1;
      checkOutput("single_ready_after_rst", oREADY, 1);
      @(posedge iCLK); #1 iVALID = 1'b0;
      waitIdle(50);
      checkOutput("single_cnt", oWORD_CNT, 1);
      checkOutput("single_low_cycles", lowCnt, 1);
      checkOutput("single_done_pulses", doneCnt, 1);
      if (firstWords.size() > 0) checkOutput("single_data", firstWords[0], 32'hA5A5_0001);
      else checkOutput("single_data_missing", firstWords.size(), 1);

      // Continuous stream of 600 incrementing words
      resetDut();
      iTXE_N = 1'b0;
      applyStimulus(600, 32'h0, 1'b0, 100, 2000);
      waitIdle(100);
      checkOutput("stream_bursts", burstLens.size(), 3);
      checkIdx("stream_burst0", burstLens, 0, 256);
      checkIdx("stream_burst1", burstLens, 1, 256);
      checkIdx("stream_burst2", burstLens, 2, 88);
      checkIdx("stream_gap0", gapLens, 0, 3);
      checkIdx("stream_gap1", gapLens, 1, 3);
      checkOutput("stream_cnt", oWORD_CNT, 600);
      begin : capchk
         int errs = 0;
         foreach (capWords[i]) if (capWords[i] !== 32'(i)) errs++;
         checkOutput("stream_capture_len", capWords.size(), 600);
         checkOutput("stream_capture_errs", errs, 0);
      end

      // TXE_N back-pressure after the 10th accepted word
      resetDut();
      iTXE_N = 1'b0;
      fork
         applyStimulus(20, 32'hB000_0000, 1'b0, 100, 2000);
         begin : txe36
            int c = 0;
            while (mcnt < 10 && c < 500) begin @(posedge iCLK); c++; end
            #1 iTXE_N = 1'b1;
            repeat (5) @(posedge iCLK);
            #1;
            checkOutput("txe_hold_cnt", oWORD_CNT, 10);
            checkOutput("txe_hold_head", oDATA, 32'hB000_000A);
            checkOutput("txe_hold_wr_n", oWR_N, 1);
            iTXE_N = 1'b0;
         end
      join
      waitIdle(100);
      checkIdx("txe_burst0", burstLens, 0, 10);
      if (firstWords.size() > 1) checkOutput("txe_resume_first", firstWords[1], 32'hB000_000A);
      else checkOutput("txe_resume_missing", firstWords.size(), 2);
      checkOutput("txe_cnt", oWORD_CNT, 20);

      // FTDI full: FIFO fills and stalls
      resetDut();
      iTXE_N = 1'b1; iVALID = 1'b1; iBE = 4'hF; iDATA = 32'hC0DE_0000;
      repeat (10) begin @(posedge iCLK); #1 iDATA = iDATA + 1; end
      checkOutput("full_pushes", pushCnt, 2);
      checkOutput("full_ready", oREADY, 0);
      checkOutput("full_wr_n", oWR_N, 1);
      checkOutput("full_oe", oDATA_OE, 0);
      iVALID = 1'b0; iTXE_N = 1'b0;
      waitIdle(50);
      checkOutput("full_cnt", oWORD_CNT, 2);

      // Reset mid-burst
      resetDut();
      iTXE_N = 1'b0; iBE = 4'hF;
      begin : r38
         int c = 0;
         while (lowCnt < 5 && c < 100) begin
            iVALID = 1'b1; iDATA = 32'hD000_0000 + c;
            @(posedge iCLK); #1; c++;
         end
      end
      #3;
      checkOutput("midrst_pre_wr_n", oWR_N, 0);
      iRESET_N = 1'b0;
      #1;
      checkOutput("midrst_wr_n", oWR_N, 1);
      checkOutput("midrst_oe", oDATA_OE, 0);
      checkOutput("midrst_cnt", oWORD_CNT, 0);
      iVALID = 1'b0;
      repeat (2) @(posedge iCLK);
      #1 iRESET_N = 1'b1;
      repeat (6) begin
         @(posedge iCLK); #2;
         checkOutput("midrst_after_oe", oDATA_OE, 0);
         checkOutput("midrst_after_ready", oREADY, 1);
      end

      // Randomised traffic with random FTDI back-pressure
      resetDut();
      stimDone = 0;
      fork
         begin applyStimulus(300, 32'h0, 1'b1, 60, 5000); stimDone = 1; end
         begin : txeRand
            int c = 0;
            while (!stimDone && c < 6000) begin
               iTXE_N = ($urandom_range(3) == 0);
               @(posedge iCLK); #1; c++;
            end
         end
      join
      iTXE_N = 1'b0;
      waitIdle(100);
      checkOutput("rand_cnt", oWORD_CNT, 300);

      // Word counter wrap
      resetDut();
      iTXE_N = 1'b0;
      applyStimulus(65537, 32'h0, 1'b0, 100, 70000);
      waitIdle(100);
      checkOutput("wrap_cnt", oWORD_CNT, 1);
      checkOutput("wrap_pops", capWords.size(), 65537);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
